tdm_demux: RTL and testbench

Round-robin TDM demultiplexer: the receive-side counterpart of the input round-robin mux. It accepts the time-interleaved product stream leaving the DSP multiplier in the `clk200m` domain and steers each beat to a per-channel FIFO by slot position. Each FIFO drains through an independent valid/ready port. A frame marker keeps slot alignment, and the block flags slot slips and per-channel overflow.

---
 rtl/tdm_pkg.sv | 18 +
 rtl/tdm_chan_fifo.sv | 55 +++++
 rtl/tdm_demux.sv | 92 +++++++++
 tb/tb_tdm_demux.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types and helpers for the TDM round-robin mux/demux pair.
`default_nettype none

package tdm_pkg;

  typedef enum logic [0:0] {
    UNSYNCED = 1'b0,
    SYNCED   = 1'b1
  } tdm_sync_state_t;

  // Slot counter width; a single-slot frame still gets a 1-bit counter.
  function automatic int tdm_slot_width(input int num_slots);
    return (num_slots > 1) ? $clog2(num_slots) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tdm_chan_fifo.sv
// tdm_chan_fifo: first-word-fall-through channel FIFO with a sticky drop flag.
`default_nettype none

module tdm_chan_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic [AW:0]           count;
  logic                  do_pop;
  logic                  do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the incoming beat needs.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/tdm_demux.sv
// tdm_demux: steers an interleaved TDM beat stream into per-channel FWFT FIFOs
// by slot position, with frame-marker resynchronisation and slip reporting.
`default_nettype none

module tdm_demux
  import tdm_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_CHANNELS = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [DATA_WIDTH-1:0]                    tdm_data,
  input  logic                                     tdm_valid,
  input  logic                                     tdm_sof,
  output logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]  ch_data,
  output logic [NUM_CHANNELS-1:0]                  ch_valid,
  input  logic [NUM_CHANNELS-1:0]                  ch_ready,
  output logic [NUM_CHANNELS-1:0]                  overflow,
  output logic                                     sync_err,
  output logic [tdm_slot_width(NUM_CHANNELS)-1:0]  slot
);

  localparam int             SW        = tdm_slot_width(NUM_CHANNELS);
  localparam logic [SW-1:0]  LAST_SLOT = SW'(NUM_CHANNELS - 1);

  tdm_sync_state_t           state;
  logic [DATA_WIDTH-1:0]     in_data;
  logic                      in_valid;
  logic                      in_sof;
  logic                      accept;
  logic [SW-1:0]             dest;
  logic [NUM_CHANNELS-1:0]   push;
  logic [NUM_CHANNELS-1:0]   empty;
  logic [NUM_CHANNELS-1:0]   unused_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_data  <= '0;
      in_valid <= 1'b0;
      in_sof   <= 1'b0;
    end else begin
      in_data  <= tdm_data;
      in_valid <= tdm_valid;
      in_sof   <= tdm_valid && tdm_sof;
    end
  end

  // Until the first frame marker nothing is written; a marker always forces slot 0.
  always_comb begin
    accept = in_valid && (in_sof || (state == SYNCED));
    dest   = in_sof ? '0 : slot;
    push   = '0;
    if (accept) push[dest] = 1'b1;
  end

  assign sync_err = !rst && in_valid && in_sof && (state == SYNCED) && (slot != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= UNSYNCED;
      slot  <= '0;
    end else if (accept) begin
      state <= SYNCED;
      if (in_sof)                 slot <= SW'(1);
      else if (slot == LAST_SLOT) slot <= '0;
      else                        slot <= slot + SW'(1);
    end
  end

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
    tdm_chan_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[i]),
      .push_data (in_data),
      .pop       (ch_ready[i]),
      .head      (ch_data[i]),
      .full      (unused_full[i]),
      .empty     (empty[i]),
      .overflow  (overflow[i])
    );
    assign ch_valid[i] = !empty[i];
  end

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed and randomized checks of tdm_demux against a queue model.
`default_nettype none

module tb_tdm_demux;

  localparam int DW    = 16;
  localparam int NCH   = 2;
  localparam int DEPTH = 4;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [DW-1:0]            tdm_data = '0;
  logic                     tdm_valid = 1'b0;
  logic                     tdm_sof = 1'b0;
  logic [NCH-1:0][DW-1:0]   ch_data;
  logic [NCH-1:0]           ch_valid;
  logic [NCH-1:0]           ch_ready = '0;
  logic [NCH-1:0]           overflow;
  logic                     sync_err;
  logic [0:0]               slot;

  tdm_demux #(
    .DATA_WIDTH   (DW),
    .NUM_CHANNELS (NCH),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tdm_data  (tdm_data),
    .tdm_valid (tdm_valid),
    .tdm_sof   (tdm_sof),
    .ch_data   (ch_data),
    .ch_valid  (ch_valid),
    .ch_ready  (ch_ready),
    .overflow  (overflow),
    .sync_err  (sync_err),
    .slot      (slot)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int sync_cnt = 0;
  bit chk_en = 1'b0;

  // Reference model: per-channel contents, sticky drop flags, sync state.
  int unsigned q    [NCH][$];
  int unsigned mlog [NCH][$];
  int unsigned dlog [NCH][$];
  int unsigned none [$];
  bit [NCH-1:0] m_ovf;
  bit           m_sync;
  int           m_slot;
  bit           p_valid, p_sof;
  int unsigned  p_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int ch;
    for (int i = 0; i < NCH; i++)
      if (q[i].size() != 0 && ch_ready[i]) mlog[i].push_back(q[i].pop_front());
    if (rst) begin
      for (int i = 0; i < NCH; i++) q[i].delete();
      m_ovf = '0; m_sync = 1'b0; m_slot = 0; p_valid = 1'b0; p_sof = 1'b0;
    end else begin
      if (p_valid) begin
        ch = -1;
        if (p_sof) begin
          ch = 0; m_sync = 1'b1; m_slot = 1;
        end else if (m_sync) begin
          ch = m_slot; m_slot = (m_slot + 1) % NCH;
        end
        if (ch >= 0) begin
          if (q[ch].size() < DEPTH) q[ch].push_back(p_data);
          else m_ovf[ch] = 1'b1;
        end
      end
      p_valid = tdm_valid;
      p_sof   = tdm_valid && tdm_sof;
      p_data  = tdm_data;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int i = 0; i < NCH; i++) begin
        chk($sformatf("ch_valid[%0d]", i), ch_valid[i], q[i].size() != 0);
        if (q[i].size() != 0) chk($sformatf("ch_data[%0d]", i), ch_data[i], q[i][0]);
        if (ch_valid[i] && ch_ready[i]) dlog[i].push_back(ch_data[i]);
      end
      chk("overflow", overflow, m_ovf);
      chk("slot", slot, m_slot);
      chk("sync_err", sync_err, !rst && p_valid && p_sof && m_sync && (m_slot != 0));
      if (sync_err === 1'b1) sync_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic s);
    tdm_valid = 1'b1; tdm_data = d; tdm_sof = s;
    tick(1);
    tdm_valid = 1'b0; tdm_sof = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    for (int i = 0; i < NCH; i++) begin
      mlog[i].delete();
      dlog[i].delete();
    end
    sync_cnt = 0;
  endtask

  task automatic chk_log(input string name, input int ch, input int unsigned exp[$]);
    chk({name, " model count"}, mlog[ch].size(), exp.size());
    chk({name, " dut count"}, dlog[ch].size(), exp.size());
    for (int k = 0; k < exp.size(); k++) begin
      if (k < mlog[ch].size()) chk($sformatf("%s model[%0d]", name, k), mlog[ch][k], exp[k]);
      if (k < dlog[ch].size()) chk($sformatf("%s dut[%0d]", name, k), dlog[ch][k], exp[k]);
    end
  endtask

  initial begin
    int pos;
    tick(1);
    chk_en = 1'b1;
    rst = 1'b0;
    chk("reset ch_valid", ch_valid, 0);
    chk("reset ch_data", ch_data, 0);
    chk("reset slot", slot, 0);

    // Aligned frames, first word two cycles after first beat.
    ch_ready = '1; clear_logs();
    send(16'h0011, 1'b1);
    chk("t1 ch_valid[0] early", ch_valid[0], 1'b0);
    send(16'h0022, 1'b0);
    chk("t1 ch_valid[0] n+2", ch_valid[0], 1'b1);
    chk("t1 ch_data[0] n+2", ch_data[0], 16'h0011);
    send(16'h0033, 1'b1);
    send(16'h0044, 1'b0);
    tick(4);
    chk_log("t1 ch0", 0, '{32'h11, 32'h33});
    chk_log("t1 ch1", 1, '{32'h22, 32'h44});
    chk("t1 sync_err count", sync_cnt, 0);

    // Unsynced beats are discarded.
    do_reset(); clear_logs();
    send(16'h00B1, 1'b0); send(16'h00B2, 1'b0); send(16'h00B3, 1'b0);
    send(16'h00A0, 1'b1); send(16'h00A1, 1'b0);
    tick(4);
    chk_log("t2 ch0", 0, '{32'hA0});
    chk_log("t2 ch1", 1, '{32'hA1});

    // Slot slip.
    do_reset(); ch_ready = '0; clear_logs();
    send(16'h0001, 1'b1);
    send(16'h0002, 1'b1);
    chk("t3 sync_err pulse", sync_err, 1'b1);
    tick(2);
    chk("t3 sync_err count", sync_cnt, 1);
    chk("t3 slot", slot, 1'b1);
    chk("t3 ch_valid[1]", ch_valid[1], 1'b0);
    ch_ready = '1;
    tick(3);
    chk_log("t3 ch0", 0, '{32'h1, 32'h2});
    chk_log("t3 ch1", 1, none);

    // Channel 1 stalled: overflow after four entries.
    do_reset(); ch_ready = 2'b01; clear_logs();
    for (int f = 0; f < 6; f++) begin
      send(16'h0100 + 16'(f), 1'b1);
      send(16'h0200 + 16'(f), 1'b0);
    end
    tick(3);
    chk("t4 overflow", overflow, 2'b10);
    ch_ready = '1;
    tick(8);
    chk_log("t4 ch0", 0, '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105});
    chk_log("t4 ch1", 1, '{32'h200, 32'h201, 32'h202, 32'h203});

    // Write into a full FIFO while it pops.
    do_reset(); ch_ready = 2'b01; clear_logs();
    for (int f = 0; f < 4; f++) begin
      send(16'h0100 + 16'(f), 1'b1);
      send(16'h0200 + 16'(f), 1'b0);
    end
    send(16'h0300, 1'b1);
    tdm_valid = 1'b1; tdm_data = 16'h0304; tdm_sof = 1'b0;
    tick(1);
    tdm_valid = 1'b0;
    ch_ready = 2'b11;
    tick(1);
    ch_ready = 2'b01;
    chk("t5 overflow", overflow, 2'b00);
    tick(2);
    ch_ready = '1;
    tick(8);
    chk_log("t5 ch1", 1, '{32'h200, 32'h201, 32'h202, 32'h203, 32'h304});
    chk("t5 overflow end", overflow, 2'b00);

    // Mid-stream reset flushes and desyncs.
    do_reset(); ch_ready = '0; clear_logs();
    send(16'h0041, 1'b1); send(16'h0042, 1'b0);
    send(16'h0043, 1'b1); send(16'h0044, 1'b0);
    tick(2);
    chk("t6 filled", ch_valid, 2'b11);
    rst = 1'b1; tdm_valid = 1'b1; tdm_sof = 1'b1; tdm_data = 16'h0099;
    tick(1);
    rst = 1'b0; tdm_valid = 1'b0; tdm_sof = 1'b0;
    chk("t6 ch_valid", ch_valid, 2'b00);
    chk("t6 overflow", overflow, 2'b00);
    chk("t6 slot", slot, 1'b0);
    chk("t6 ch_data", ch_data, 0);
    send(16'h0055, 1'b0);
    tick(3);
    chk("t6 dropped", ch_valid, 2'b00);

    // Randomized traffic with occasional resets and slips.
    pos = 0;
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      tdm_valid = ($urandom_range(0, 3) != 0);
      tdm_data  = DW'($urandom_range(0, 65535));
      tdm_sof   = (pos == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 15) == 0);
      if (tdm_valid) pos = (pos + 1) % NCH;
      ch_ready  = NCH'($urandom_range(0, 3));
      tick(1);
    end
    rst = 1'b0; tdm_valid = 1'b0; tdm_sof = 1'b0; ch_ready = '1;
    tick(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
